// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM states, frame
// fall indices and the parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    XMIT      = 3'd3,
    WAIT_IDLE = 3'd4
  } ps2_state_t;

  // Device clock falls counted from clock release to end of frame.
  localparam logic [3:0] FRAME_FALLS = 4'd11;
  localparam logic [3:0] ACK_FALL    = 4'd11;
  localparam logic [3:0] STOP_FALL   = 4'd10;
  localparam logic [3:0] PARITY_FALL = 4'd9;

  // PS/2 uses odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus a
// falling-edge detect on the synchronized clock. The receiver uses the same
// block so both directions see the lines with identical latency.
module ps2_sync_edge (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_sync,
  output logic o_data_sync,
  output logic o_clk_fall
);

  logic r_clk_s1;
  logic r_clk_s2;
  logic r_clk_prev;
  logic r_data_s1;
  logic r_data_s2;

  // Synchronizer chains; idle lines are pulled high, so reset to 1.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
    end else begin
      r_clk_s1   <= i_ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_data_s1  <= i_ps2_data;
      r_data_s2  <= r_data_s1;
    end
  end

  assign o_clk_sync  = r_clk_s2;
  assign o_data_sync = r_data_s2;
  assign o_clk_fall  = r_clk_prev & ~r_clk_s2;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Accepts one byte via valid/ready, inhibits
// the clock, issues the request-to-send, shifts data/parity/stop on device
// clock falls, samples the device ACK and reports done or timeout. Lines are
// open-drain: the *_oe outputs only request a pull-low.
//
// Handshake: a byte transfers on a rising clock edge where tx_valid and
// tx_ready are both 1. tx_ready is 1 only in IDLE; tx_valid is ignored at
// every other time, and nothing is queued.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout,
  output logic [2:0] dbg_state
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  logic w_clk_sync;
  logic w_data_sync;
  logic w_clk_fall;

  ps2_sync_edge u_sync (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .o_clk_sync  (w_clk_sync),
    .o_data_sync (w_data_sync),
    .o_clk_fall  (w_clk_fall)
  );

  ps2_state_t       r_state,   w_state;
  logic [INH_W-1:0] r_inh_cnt, w_inh_cnt;
  logic [3:0]       r_bit_cnt, w_bit_cnt;
  logic [WD_W-1:0]  r_wdog,    w_wdog;
  logic [7:0]       r_data,    w_data;
  logic             r_parity,  w_parity;
  logic             r_ack,     w_ack;
  logic             r_tx_ready, w_tx_ready;
  logic             r_clk_oe,  w_clk_oe;
  logic             r_data_oe, w_data_oe;
  logic             r_busy,    w_busy;
  logic             r_done,    w_done;
  logic             r_ack_ok,  w_ack_ok;
  logic             r_timeout, w_timeout;
  logic [3:0]       w_bit_next;
  logic             w_wd_expire;

  assign w_bit_next  = r_bit_cnt + 4'd1;
  assign w_wd_expire = (r_wdog == WD_LAST);

  // Next-state and next-output logic; every output is registered, so the
  // values computed here appear the cycle after the deciding edge.
  always_comb begin
    w_state    = r_state;
    w_inh_cnt  = r_inh_cnt;
    w_bit_cnt  = r_bit_cnt;
    w_wdog     = r_wdog;
    w_data     = r_data;
    w_parity   = r_parity;
    w_ack      = r_ack;
    w_tx_ready = 1'b0;
    w_clk_oe   = 1'b0;
    w_data_oe  = 1'b0;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    w_ack_ok   = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy     = 1'b0;
        w_tx_ready = 1'b1;
        if (tx_valid) begin
          w_state    = INHIBIT;
          w_data     = tx_data;
          w_parity   = odd_parity(tx_data);
          w_inh_cnt  = '0;
          w_clk_oe   = 1'b1;
          w_busy     = 1'b1;
          w_tx_ready = 1'b0;
        end
      end
      INHIBIT: begin
        w_clk_oe = 1'b1;
        if (r_inh_cnt == INH_LAST) begin
          w_state   = REQ;
          w_data_oe = 1'b1;
        end else begin
          w_inh_cnt = r_inh_cnt + 1'b1;
        end
      end
      REQ: begin
        // Start bit stays on the data line as the clock is released.
        w_state   = XMIT;
        w_data_oe = 1'b1;
        w_bit_cnt = '0;
        w_wdog    = '0;
      end
      XMIT: begin
        w_data_oe = r_data_oe;
        w_wdog    = r_wdog + 1'b1;
        if (w_wd_expire) begin
          w_state    = IDLE;
          w_data_oe  = 1'b0;
          w_timeout  = 1'b1;
          w_busy     = 1'b0;
          w_tx_ready = 1'b1;
        end else if (w_clk_fall) begin
          w_bit_cnt = w_bit_next;
          if (w_bit_next <= 4'd8) begin
            w_data_oe = ~r_data[r_bit_cnt[2:0]];
          end else if (w_bit_next == PARITY_FALL) begin
            w_data_oe = ~r_parity;
          end else if (w_bit_next == STOP_FALL) begin
            w_data_oe = 1'b0;
          end else begin
            // ACK_FALL: device pulls data low to acknowledge.
            w_data_oe = 1'b0;
            w_ack     = ~w_data_sync;
            w_state   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        w_wdog = r_wdog + 1'b1;
        if (w_wd_expire) begin
          w_state    = IDLE;
          w_timeout  = 1'b1;
          w_busy     = 1'b0;
          w_tx_ready = 1'b1;
        end else if (w_clk_sync && w_data_sync) begin
          w_state    = IDLE;
          w_done     = 1'b1;
          w_ack_ok   = r_ack;
          w_busy     = 1'b0;
          w_tx_ready = 1'b1;
        end
      end
      default: begin
        w_state    = IDLE;
        w_busy     = 1'b0;
        w_tx_ready = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_inh_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_wdog     <= '0;
      r_data     <= '0;
      r_parity   <= 1'b0;
      r_ack      <= 1'b0;
      r_tx_ready <= 1'b1;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ack_ok   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_inh_cnt  <= w_inh_cnt;
      r_bit_cnt  <= w_bit_cnt;
      r_wdog     <= w_wdog;
      r_data     <= w_data;
      r_parity   <= w_parity;
      r_ack      <= w_ack;
      r_tx_ready <= w_tx_ready;
      r_clk_oe   <= w_clk_oe;
      r_data_oe  <= w_data_oe;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_ack_ok   <= w_ack_ok;
      r_timeout  <= w_timeout;
    end
  end

  assign tx_ready    = r_tx_ready;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign busy        = r_busy;
  assign done        = r_done;
  assign ack_ok      = r_ack_ok;
  assign timeout     = r_timeout;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain line model and a simple
// PS/2 device that clocks frames, samples bits on its rising clock edges and
// optionally drives the ACK.
module tb_ps2_host_tx;

  localparam int INH = 5000;
  localparam int TO  = 2000;
  localparam int H   = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       timeout;
  logic [2:0] dbg_state;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int n_done = 0;
  int n_timeout = 0;

  // Wired-AND open-drain lines with pull-ups.
  assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .timeout     (timeout),
    .dbg_state   (dbg_state)
  );

  // Clock generation.
  always #5 clock = ~clock;

  // Pulse counters for done/timeout.
  always @(negedge clock) begin
    if (done === 1'b1) n_done++;
    if (timeout === 1'b1) n_timeout++;
  end

  // Hand a byte to the DUT and follow it through inhibit/request/release.
  // With junk=1, tx_valid stays high carrying junk_b after acceptance.
  task automatic start_byte(input logic [7:0] b, input bit junk, input logic [7:0] junk_b);
    int n;
    @(negedge clock);
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL ready_idle: got %b want 1", tx_ready); end
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clock);
    if (junk) tx_data = junk_b;
    else tx_valid = 1'b0;
    vectors++; if ({tx_ready, busy} !== 2'b01) begin miscompares++; $display("FAIL accept: ready/busy got %b%b want 01", tx_ready, busy); end
    n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < INH + 10) begin
      n++;
      @(negedge clock);
    end
    vectors++; if (n !== INH) begin miscompares++; $display("FAIL inhibit_len: got %0d want %0d", n, INH); end
    vectors++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin miscompares++; $display("FAIL req: clk/data oe got %b%b want 11", ps2_clk_oe, ps2_data_oe); end
    @(negedge clock);
    vectors++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin miscompares++; $display("FAIL release: clk/data oe got %b%b want 01", ps2_clk_oe, ps2_data_oe); end
  endtask

  // Device clocks a full frame; checks bits, done/ack_ok and ready.
  task automatic run_frame(input string tag, input logic [7:0] b, input logic par, input bit give_ack);
    logic [10:0] bits;
    logic [10:0] exp_bits;
    int n;
    int d0;
    int t0;
    d0 = n_done;
    t0 = n_timeout;
    exp_bits = {1'b1, par, b, 1'b0};
    repeat (10) @(negedge clock);
    bits[0] = ps2_data;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clock);
      dev_clk_low = 1'b0;
      bits[k] = ps2_data;
      repeat (H) @(negedge clock);
    end
    tx_valid = 1'b0;
    dev_data_low = give_ack;
    repeat (4) @(negedge clock);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clock);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    vectors++; if (bits !== exp_bits) begin miscompares++; $display("FAIL %s bits: got %b want %b", tag, bits, exp_bits); end
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      n++;
      @(negedge clock);
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL %s done: got %b want 1", tag, done); end
    vectors++; if (ack_ok !== give_ack) begin miscompares++; $display("FAIL %s ack_ok: got %b want %b", tag, ack_ok, give_ack); end
    @(negedge clock);
    vectors++; if ({done, tx_ready, busy} !== 3'b010) begin miscompares++; $display("FAIL %s after_done: done/ready/busy got %b%b%b want 010", tag, done, tx_ready, busy); end
    repeat (3) @(negedge clock);
    vectors++; if (n_done - d0 !== 1) begin miscompares++; $display("FAIL %s done_count: got %0d want 1", tag, n_done - d0); end
    vectors++; if (n_timeout - t0 !== 0) begin miscompares++; $display("FAIL %s timeout_count: got %0d want 0", tag, n_timeout - t0); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if ({tx_ready, busy, done, ack_ok, timeout, ps2_clk_oe, ps2_data_oe} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 1000000", {tx_ready, busy, done, ack_ok, timeout, ps2_clk_oe, ps2_data_oe});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_send_ed();
    start_byte(8'hED, 1'b0, 8'h00);
    run_frame("ed", 8'hED, 1'b1, 1'b1);
  endtask

  task automatic test_patterns();
    start_byte(8'h00, 1'b0, 8'h00);
    run_frame("x00", 8'h00, 1'b1, 1'b1);
    start_byte(8'hFF, 1'b0, 8'h00);
    run_frame("xff", 8'hFF, 1'b1, 1'b1);
  endtask

  task automatic test_no_ack();
    start_byte(8'hA5, 1'b0, 8'h00);
    run_frame("noack", 8'hA5, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int n;
    int d0;
    d0 = n_done;
    start_byte(8'h11, 1'b0, 8'h00);
    n = 0;
    while (timeout !== 1'b1 && n < TO + 50) begin
      @(negedge clock);
      n++;
    end
    vectors++; if (n !== TO) begin miscompares++; $display("FAIL timeout_latency: got %0d want %0d", n, TO); end
    vectors++; if ({ps2_clk_oe, ps2_data_oe, done} !== 3'b000) begin miscompares++; $display("FAIL timeout_lines: clk/data oe, done got %b%b%b want 000", ps2_clk_oe, ps2_data_oe, done); end
    @(negedge clock);
    vectors++; if ({timeout, tx_ready, busy} !== 3'b010) begin miscompares++; $display("FAIL timeout_after: timeout/ready/busy got %b%b%b want 010", timeout, tx_ready, busy); end
    vectors++; if (n_done !== d0) begin miscompares++; $display("FAIL timeout_no_done: got %0d want %0d", n_done, d0); end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    int t0;
    start_byte(8'h0F, 1'b0, 8'h00);
    d0 = n_done;
    t0 = n_timeout;
    repeat (10) @(negedge clock);
    for (int k = 1; k <= 4; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clock);
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clock);
    end
    dev_clk_low = 1'b1;
    repeat (6) @(negedge clock);
    // Fall 5 puts bit 4 of 0x0F (a 0) on the line.
    vectors++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin miscompares++; $display("FAIL fall5_lines: clk/data oe got %b%b want 01", ps2_clk_oe, ps2_data_oe); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, done, timeout, tx_ready, busy} !== 6'b000010) begin
      miscompares++;
      $display("FAIL midreset: oe/oe/done/timeout/ready/busy got %b want 000010", {ps2_clk_oe, ps2_data_oe, done, timeout, tx_ready, busy});
    end
    dev_clk_low = 1'b0;
    repeat (TO + 200) @(negedge clock);
    vectors++; if ((n_done - d0) !== 0 || (n_timeout - t0) !== 0) begin miscompares++; $display("FAIL midreset_pulses: done %0d timeout %0d want 0 0", n_done - d0, n_timeout - t0); end
    start_byte(8'h02, 1'b0, 8'h00);
    run_frame("x02", 8'h02, 1'b0, 1'b1);
  endtask

  task automatic test_busy_ignore();
    start_byte(8'h5A, 1'b1, 8'hC3);
    vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL busy_ready: got %b want 0", tx_ready); end
    run_frame("busy", 8'h5A, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_patterns();
    test_no_ack();
    test_timeout();
    test_reset_mid_frame();
    test_busy_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
